sprite_arbiter: RTL
===================

SPRITE_ARBITER -- requirements
Module: sprite_arbiter

Interface
REQ-001 SHALL have parameter CANVAS_WIDTH, default 360, meaning the canvas x extent in pixels; XW = $clog2(CANVAS_WIDTH).
REQ-002 SHALL have parameter CANVAS_HEIGHT, default 720, meaning the canvas y extent in pixels; YW = $clog2(CANVAS_HEIGHT).
REQ-003 SHALL have parameter NUM_FRAMES, default 5, meaning the number of sprite animation frames; FW = $clog2(NUM_FRAMES).
REQ-004 SHALL have parameter MAX_SPRITES, default 64, meaning the per-video-frame sprite budget; CW = $clog2(MAX_SPRITES+1).
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports are listed in REQ-006 to REQ-019.
REQ-006 clk_pixel  input  1  pixel clock; the only clock.
REQ-007 rst_in_n  input  1  asynchronous, active-low reset.
REQ-008 new_frame  input  1  single-cycle pulse at the start of each video frame.
REQ-009 a_valid, a_ready  input/output  1 each  handshake for requester A.
REQ-010 a_x, a_y, a_frame  input  XW/YW/FW  sprite payload from requester A.
REQ-011 b_valid, b_ready  input/output  1 each  handshake for requester B.
REQ-012 b_x, b_y, b_frame  input  XW/YW/FW  sprite payload from requester B.
REQ-013 sprite_valid  output  1  payload to the graphics block is valid.
REQ-014 sprite_ready  input  1  the graphics block accepts the payload.
REQ-015 sprite_x, sprite_y, sprite_frame_number  output  XW/YW/FW  registered payload.
REQ-016 sprite_count  output  CW  number of sprites accepted in the current frame.
REQ-017 budget_hit  output  1  sticky flag; the budget was reached in this frame.
REQ-018 grant_b  output  1  the most recent grant went to B.
REQ-019 drop_pulse  output  1  single-cycle pulse when a sprite is discarded by clipping.

Function
REQ-020 SHALL implement FSM states ACCEPT and BLOCKED; the state SHALL be ACCEPT after reset.
REQ-021 A transfer SHALL occur on a requester when its valid and ready are both 1 on the same clk_pixel edge.
REQ-022 A single-entry output register is "free" when sprite_valid==0 or sprite_ready==1.
REQ-023 In ACCEPT with the output register free, exactly one requester SHALL be readied.
REQ-024 Arbitration: only one valid -> that requester; both valid -> the requester not granted last (round-robin, tie-break A after reset).
REQ-025 a_ready and b_ready SHALL be 0 in BLOCKED and whenever the output register is not free.
REQ-026 Ready SHALL be combinational from the valids, the state and the output register status, and SHALL NOT depend on the payload.
REQ-027 An accepted sprite SHALL appear on sprite_* one cycle later (latency 1); this gives full throughput of 1 sprite per cycle when sprite_ready is held at 1.
REQ-028 While sprite_valid==1 and sprite_ready==0, sprite_* SHALL hold stable.
REQ-029 Each accept SHALL increment sprite_count, and grant_b SHALL update to the granted side.
REQ-030 Budget: when an accept takes sprite_count to MAX_SPRITES, the next state SHALL be BLOCKED and budget_hit SHALL be set to 1.
REQ-031 new_frame SHALL set the state to ACCEPT, clear budget_hit and reset sprite_count to 0, plus 1 if an accept occurs in the same cycle (an accept in that cycle is allowed only if the pre-pulse state permits it).
REQ-032 new_frame SHALL NOT flush the output register.
REQ-033 A requester held off by the budget SHALL keep its request pending; no payload SHALL be lost.
REQ-034 All arithmetic SHALL be unsigned; sprite_count SHALL never exceed MAX_SPRITES.

Reset
REQ-035 Asserting rst_in_n low at any time, including mid-handshake, SHALL immediately force: state=ACCEPT, sprite_valid=0, sprite_x/y/frame_number=0, sprite_count=0, budget_hit=0, grant_b=1 (so A wins first), drop_pulse=0.
REQ-036 While in reset, a_ready and b_ready SHALL be 0.
REQ-037 Reset deassertion SHALL be synchronised to clk_pixel internally.

Configuration
REQ-038 Macro SPRITE_ARB_CLIP_EN defined: an accepted sprite with x>=CANVAS_WIDTH or y>=CANVAS_HEIGHT SHALL still be consumed (ready given), SHALL NOT load the output register, SHALL NOT count against the budget, and SHALL pulse drop_pulse for 1 cycle.
REQ-039 Macro SPRITE_ARB_CLIP_EN undefined: all accepted sprites SHALL be forwarded unchanged, and drop_pulse SHALL be tied to 0.

Verification
REQ-040 Only a_valid high with a_x=10, a_y=20, a_frame=3 and sprite_ready=1 -> next cycle sprite_valid=1 with 10/20/3, sprite_count=1.
REQ-041 a_valid and b_valid held high for 4 cycles with sprite_ready=1 -> grant order A,B,A,B and sprite_count=4.
REQ-042 sprite_ready=0 for 5 cycles with both requesters valid -> payload stable, a_ready=b_ready=0, sprite_count unchanged.
REQ-043 With MAX_SPRITES=4 and 6 requests from A -> 4 forwarded, budget_hit=1, a_ready=0; on new_frame the remaining 2 are forwarded and sprite_count=2.
REQ-044 rst_in_n pulled low while sprite_valid=1 and sprite_count=7 -> same-cycle sprite_valid=0, sprite_count=0; first post-reset grant goes to A.
REQ-045 With SPRITE_ARB_CLIP_EN defined, a_x=400 -> a_ready=1, drop_pulse=1 for 1 cycle, sprite_valid stays 0, sprite_count unchanged.

Source files
------------

// File: rtl/sprite_arbiter_if.sv
// sprite_arbiter_if: requester, graphics-side and status signals of the sprite arbiter
interface sprite_arbiter_if #(
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720,
    parameter int NUM_FRAMES    = 5,
    parameter int MAX_SPRITES   = 64
);
    localparam int XW = $clog2(CANVAS_WIDTH);
    localparam int YW = $clog2(CANVAS_HEIGHT);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int CW = $clog2(MAX_SPRITES + 1);

    logic          new_frame;
    logic          a_valid;
    logic          a_ready;
    logic [XW-1:0] a_x;
    logic [YW-1:0] a_y;
    logic [FW-1:0] a_frame;
    logic          b_valid;
    logic          b_ready;
    logic [XW-1:0] b_x;
    logic [YW-1:0] b_y;
    logic [FW-1:0] b_frame;
    logic          sprite_valid;
    logic          sprite_ready;
    logic [XW-1:0] sprite_x;
    logic [YW-1:0] sprite_y;
    logic [FW-1:0] sprite_frame_number;
    logic [CW-1:0] sprite_count;
    logic          budget_hit;
    logic          grant_b;
    logic          drop_pulse;

    modport master (
        output new_frame, a_valid, a_x, a_y, a_frame, b_valid, b_x, b_y, b_frame, sprite_ready,
        input  a_ready, b_ready, sprite_valid, sprite_x, sprite_y, sprite_frame_number,
               sprite_count, budget_hit, grant_b, drop_pulse
    );

    modport slave (
        input  new_frame, a_valid, a_x, a_y, a_frame, b_valid, b_x, b_y, b_frame, sprite_ready,
        output a_ready, b_ready, sprite_valid, sprite_x, sprite_y, sprite_frame_number,
               sprite_count, budget_hit, grant_b, drop_pulse
    );
endinterface

// File: rtl/sprite_arbiter.sv
// sprite_arbiter: round-robin two-requester sprite arbiter with per-frame budget; SPRITE_ARB_CLIP_EN enables off-canvas dropping
module sprite_arbiter #(
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720,
    parameter int NUM_FRAMES    = 5,
    parameter int MAX_SPRITES   = 64
) (
    input logic             clk_pixel,
    input logic             rst_in_n,
    sprite_arbiter_if.slave bus
);
    localparam int XW = $clog2(CANVAS_WIDTH);
    localparam int YW = $clog2(CANVAS_HEIGHT);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int CW = $clog2(MAX_SPRITES + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_SPRITES);

    typedef enum logic {ACCEPT = 1'b0, BLOCKED = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic          r_valid;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [FW-1:0] r_f;
    logic [CW-1:0] r_count;
    logic          r_budget;
    logic          r_grant_b;
    logic          w_free;
    logic          w_pick_b;
    logic          w_open;
    logic          w_a_ready;
    logic          w_b_ready;
    logic          w_acc_a;
    logic          w_acc_b;
    logic          w_acc;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [FW-1:0] w_f;
    logic          w_clip;
    logic          w_load;
    logic [CW-1:0] w_cnt_next;
    logic          w_hit;

    // Reset synchroniser: assertion acts at once, deassertion is released after two clk_pixel edges
    always_ff @(posedge clk_pixel or negedge rst_in_n)
        if (!rst_in_n) r_rst_sync <= 2'b00;
        else r_rst_sync <= {r_rst_sync[0], 1'b1};

    assign w_rst_n  = r_rst_sync[1];
    assign w_free   = !r_valid || bus.sprite_ready;
    assign w_pick_b = bus.b_valid && (!bus.a_valid || !r_grant_b);
    assign w_acc_a  = bus.a_valid && w_a_ready;
    assign w_acc_b  = bus.b_valid && w_b_ready;
    assign w_acc    = w_acc_a || w_acc_b;
    assign w_x      = w_acc_b ? bus.b_x : bus.a_x;
    assign w_y      = w_acc_b ? bus.b_y : bus.a_y;
    assign w_f      = w_acc_b ? bus.b_frame : bus.a_frame;
    assign w_load   = w_acc && !w_clip;
    // new_frame restarts the count; an accept in the same cycle counts against the new frame
    assign w_cnt_next = (bus.new_frame ? '0 : r_count) + CW'(w_load);
    assign w_hit      = w_load && (w_cnt_next == C_MAX);

`ifdef SPRITE_ARB_CLIP_EN
    localparam logic [XW:0] X_LIM = (XW+1)'(CANVAS_WIDTH);
    localparam logic [YW:0] Y_LIM = (YW+1)'(CANVAS_HEIGHT);
    logic r_drop;
    assign w_clip = w_acc && (({1'b0, w_x} >= X_LIM) || ({1'b0, w_y} >= Y_LIM));
    // One-cycle flag for a sprite consumed but discarded as off-canvas
    always_ff @(posedge clk_pixel or negedge w_rst_n)
        if (!w_rst_n) r_drop <= 1'b0;
        else r_drop <= w_clip;
    assign bus.drop_pulse = r_drop;
`else
    assign w_clip         = 1'b0;
    assign bus.drop_pulse = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_pixel or negedge w_rst_n)
        if (!w_rst_n) r_state <= ACCEPT;
        else r_state <= w_state_next;

    // Next state: reaching the budget blocks, a frame start reopens
    always_comb
        w_state_next = w_hit ? BLOCKED : (bus.new_frame ? ACCEPT : r_state);

    // Readies: exactly one side opened when accepting and the output register is free
    always_comb begin
        w_open    = w_rst_n && (r_state == ACCEPT) && w_free;
        w_a_ready = w_open && !w_pick_b;
        w_b_ready = w_open && w_pick_b;
    end

    // Output register, budget counter and last-grant tracking
    always_ff @(posedge clk_pixel or negedge w_rst_n)
        if (!w_rst_n) begin
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_f       <= '0;
            r_count   <= '0;
            r_budget  <= 1'b0;
            r_grant_b <= 1'b1;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_x     <= w_x;
                r_y     <= w_y;
                r_f     <= w_f;
            end else if (bus.sprite_ready) r_valid <= 1'b0;
            if (w_acc) r_grant_b <= w_acc_b;
            r_count  <= w_cnt_next;
            r_budget <= w_hit || (!bus.new_frame && r_budget);
        end

    assign bus.a_ready             = w_a_ready;
    assign bus.b_ready             = w_b_ready;
    assign bus.sprite_valid        = r_valid;
    assign bus.sprite_x            = r_x;
    assign bus.sprite_y            = r_y;
    assign bus.sprite_frame_number = r_f;
    assign bus.sprite_count        = r_count;
    assign bus.budget_hit          = r_budget;
    assign bus.grant_b             = r_grant_b;
endmodule
